// File: rtl/scanout_pkg.sv
// Shared graphics timing constants and scanout types.
// Line buffer fill and pixel path: fixed 2-cycle pixel latency; memory side waits on mem_ack.
package scanout_pkg;

  localparam int GFX_H_ACTIVE = 640;
  localparam int GFX_V_ACTIVE = 480;
  localparam int GFX_V_TOTAL  = 525;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // RGB332 -> RGB444 by replicating the top bits into the new LSBs.
  function automatic rgb444_t rgb332_expand(input logic [7:0] p);
    rgb444_t c;
    c.r = {p[7:5], p[7]};
    c.g = {p[4:2], p[4]};
    c.b = {p[1:0], p[1:0]};
    return c;
  endfunction

endpackage

// File: rtl/scanout_line_buffer.sv
// Ping-pong line store: one write port, one registered read port (read-before-write on collision).
// Read latency 1 cycle; no backpressure, both ports accept every cycle.
module line_buffer #(
  parameter int WPL = 160,
  parameter int AW  = $clog2(2*WPL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [0:2*WPL-1];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/scanout.sv
// Framebuffer scanout: prefetches the next line into a ping-pong buffer, emits RGB444 pixels.
// Pixel latency 2 cycles; fetch holds mem_req/mem_addr until mem_ack, late fetches flag underrun.
module scanout
  import scanout_pkg::*;
#(
  parameter int H_ACTIVE = GFX_H_ACTIVE,
  parameter int V_ACTIVE = GFX_V_ACTIVE,
  parameter int V_TOTAL  = GFX_V_TOTAL,
  parameter int FB_BASE  = 0,
  parameter int ADDR_W   = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       in_x,
  input  logic [15:0]       in_y,
  input  logic              in_hsync,
  input  logic              in_vsync,
  input  logic              in_visible,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_data,
  output logic              out_hsync,
  output logic              out_vsync,
  output logic              out_visible,
  output logic [3:0]        out_r,
  output logic [3:0]        out_g,
  output logic [3:0]        out_b,
  output logic              underrun
);

  localparam int WPL = H_ACTIVE / 4;
  localparam int KW  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int LBW = $clog2(2*WPL);

  fetch_state_t  state;
  logic [KW-1:0] k;
  logic [15:0]   tgt;

  logic [16:0] y_next;
  logic        t_ok;
  logic [15:0] t_new;
  logic        trig;
  logic        last_word;

  assign y_next = {1'b0, in_y} + 17'd1;

  always_comb begin
    t_ok  = 1'b0;
    t_new = '0;
    if (y_next < 17'(V_ACTIVE)) begin
      t_ok  = 1'b1;
      t_new = y_next[15:0];
    end else if (in_y == 16'(V_TOTAL - 1)) begin
      t_ok  = 1'b1;
      t_new = '0;
    end
  end

  assign trig      = (in_x == 16'(H_ACTIVE)) && t_ok;
  assign last_word = (k == KW'(WPL - 1));

  // Address of the word the FSM will present next: a fresh line on trigger, else k+1.
  logic [15:0]       a_t;
  logic [KW-1:0]     a_k;
  logic [ADDR_W-1:0] a_next;

  always_comb begin
    a_t    = trig ? t_new : tgt;
    a_k    = trig ? '0 : k + 1'b1;
    a_next = ADDR_W'(FB_BASE) + ADDR_W'(a_t) * ADDR_W'(WPL) + ADDR_W'(a_k);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      k        <= '0;
      tgt      <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      underrun <= 1'b0;
    end else begin
      if (trig) begin
        if (state == ST_FETCH) underrun <= 1'b1;
        state    <= ST_FETCH;
        tgt      <= t_new;
        k        <= '0;
        mem_req  <= 1'b1;
        mem_addr <= a_next;
      end else if (state == ST_FETCH && mem_ack) begin
        if (last_word) begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
          k       <= '0;
        end else begin
          k        <= k + 1'b1;
          mem_addr <= a_next;
        end
      end
      // Display has reached the line still being fetched.
      if (in_x == 16'd0 && in_visible && state == ST_FETCH && tgt == in_y)
        underrun <= 1'b1;
    end
  end

  logic           lb_wr_en;
  logic [LBW-1:0] lb_wr_addr;
  logic [KW-1:0]  rd_word;
  logic [LBW-1:0] lb_rd_addr;
  logic [31:0]    lb_rd_data;

  assign lb_wr_en   = (state == ST_FETCH) && mem_ack && !reset;
  assign lb_wr_addr = tgt[0] ? LBW'(WPL) + LBW'(k) : LBW'(k);

  // Blanking columns can point past the line; clamp them to word 0.
  assign rd_word    = (in_x[15:2] < 14'(WPL)) ? KW'(in_x[15:2]) : '0;
  assign lb_rd_addr = in_y[0] ? LBW'(WPL) + LBW'(rd_word) : LBW'(rd_word);

  line_buffer #(.WPL(WPL), .AW(LBW)) u_lb (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (lb_wr_en),
    .wr_addr (lb_wr_addr),
    .wr_data (mem_data),
    .rd_addr (lb_rd_addr),
    .rd_data (lb_rd_data)
  );

  logic [1:0] s1_sel;
  logic       s1_hs, s1_vs, s1_vis;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_sel <= '0;
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      s1_vis <= 1'b0;
    end else begin
      s1_sel <= in_x[1:0];
      s1_hs  <= in_hsync;
      s1_vs  <= in_vsync;
      s1_vis <= in_visible;
    end
  end

  logic [7:0] pix_byte;
  rgb444_t    pix;

  always_comb begin
    pix_byte = lb_rd_data[7:0];
    case (s1_sel)
      2'd0: pix_byte = lb_rd_data[7:0];
      2'd1: pix_byte = lb_rd_data[15:8];
      2'd2: pix_byte = lb_rd_data[23:16];
      2'd3: pix_byte = lb_rd_data[31:24];
      default: pix_byte = lb_rd_data[7:0];
    endcase
    pix = rgb332_expand(pix_byte);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_hsync   <= 1'b0;
      out_vsync   <= 1'b0;
      out_visible <= 1'b0;
      out_r       <= '0;
      out_g       <= '0;
      out_b       <= '0;
    end else begin
      out_hsync   <= s1_hs;
      out_vsync   <= s1_vs;
      out_visible <= s1_vis;
      out_r       <= s1_vis ? pix.r : 4'd0;
      out_g       <= s1_vis ? pix.g : 4'd0;
      out_b       <= s1_vis ? pix.b : 4'd0;
    end
  end

endmodule

// File: tb/tb_scanout.sv
// Scoreboarded bench for scanout: expected fetch addresses and pixels are queued by the
// stimulus and popped by a monitor on every memory handshake / visible output pixel.
module tb_scanout;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_x, in_y;
  logic        in_hsync, in_vsync, in_visible;
  logic        mem_req;
  logic [17:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        out_hsync, out_vsync, out_visible;
  logic [3:0]  out_r, out_g, out_b;
  logic        underrun;

  scanout dut (
    .clk(clk), .reset(reset),
    .in_x(in_x), .in_y(in_y),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_visible(in_visible),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_visible(out_visible),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory image: one marked word, everything else derived from its address.
  function automatic logic [31:0] data_of(input logic [17:0] a);
    if (a == 18'd1600) return 32'h44332211;
    return {a[15:0] ^ {14'd0, a[17:16]}, ~a[15:0]};
  endfunction

  assign mem_data = data_of(mem_addr);

  typedef struct {
    int         stamp;
    logic [11:0] rgb;
    logic       hs;
    logic       vs;
  } pexp_t;

  logic [17:0] exp_addr[$];
  pexp_t       exp_pix[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && mem_req && mem_ack) begin
      hs_cnt++;
      if (exp_addr.size() == 0) chk("addr_extra", 32'(mem_addr), 32'hFFFFFFFF);
      else chk("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
    end
    if (out_visible) begin
      if (exp_pix.size() == 0) chk("pix_extra", {20'd0, out_r, out_g, out_b}, 32'hFFFFFFFF);
      else begin
        pexp_t e;
        e = exp_pix.pop_front();
        chk("pix_rgb", {20'd0, out_r, out_g, out_b}, {20'd0, e.rgb});
        chk("pix_flags", {30'd0, out_hsync, out_vsync}, {30'd0, e.hs, e.vs});
        chk("pix_lat", cyc, e.stamp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_addrs(input int base, input int n);
    for (int i = 0; i < n; i++) exp_addr.push_back(18'(base + i));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_addr.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", exp_addr.size(), 0);
  endtask

  task automatic pix(input logic [15:0] x, input logic [15:0] y,
                     input logic hs, input logic vs, input logic [11:0] rgb);
    pexp_t e;
    in_x = x; in_y = y; in_hsync = hs; in_vsync = vs; in_visible = 1'b1;
    e.stamp = cyc + 2; e.rgb = rgb; e.hs = hs; e.vs = vs;
    exp_pix.push_back(e);
    tick();
  endtask

  int n0;

  initial begin
    reset = 1'b1; in_x = '0; in_y = '0;
    in_hsync = 1'b0; in_vsync = 1'b0; in_visible = 1'b0; mem_ack = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_req", {31'd0, mem_req}, 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_underrun", {31'd0, underrun}, 0);
    chk("rst_out", {17'd0, out_hsync, out_vsync, out_visible, out_r, out_g, out_b}, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_req", {31'd0, mem_req}, 0);
    chk("post_rst_out", {17'd0, out_hsync, out_vsync, out_visible, out_r, out_g, out_b}, 0);

    // Line 10 fetch, ack every cycle
    mem_ack = 1'b1; in_y = 16'd9; in_x = 16'd640;
    push_addrs(1600, 160);
    n0 = hs_cnt;
    tick();
    in_x = 16'd641;
    chk("fetch_start_req", {31'd0, mem_req}, 1);
    chk("fetch_start_addr", 32'(mem_addr), 1600);
    drain(400);
    chk("fetch_acks", hs_cnt - n0, 160);
    chk("fetch_req_fall", {31'd0, mem_req}, 0);
    tick(); tick();
    chk("idle_ack_ignored", {31'd0, mem_req}, 0);
    chk("no_underrun", {31'd0, underrun}, 0);
    mem_ack = 1'b0;

    // Pixel path from bank 0 (line 10)
    pix(16'd0,   16'd10, 1'b1, 1'b0, 12'h095);
    pix(16'd1,   16'd10, 1'b0, 1'b1, 12'h20A);
    pix(16'd2,   16'd10, 1'b1, 1'b1, 12'h29F);
    pix(16'd3,   16'd10, 1'b0, 1'b0, 12'h420);
    pix(16'd4,   16'd10, 1'b0, 1'b0, 12'hBFA);
    pix(16'd7,   16'd10, 1'b1, 1'b0, 12'h02A);
    pix(16'd636, 16'd10, 1'b0, 1'b0, 12'h200);
    pix(16'd639, 16'd10, 1'b0, 1'b1, 12'h02A);
    in_visible = 1'b0; in_hsync = 1'b1; in_vsync = 1'b0; in_x = 16'd700;
    tick();
    in_hsync = 1'b0;
    tick();
    chk("blank_hsync", {31'd0, out_hsync}, 1);
    chk("blank_vis", {31'd0, out_visible}, 0);
    chk("blank_rgb", {20'd0, out_r, out_g, out_b}, 0);
    tick();
    chk("blank_hsync_fall", {31'd0, out_hsync}, 0);

    // Wrap: last line fetches line 0; last visible line fetches nothing
    mem_ack = 1'b1; in_y = 16'd524; in_x = 16'd640;
    push_addrs(0, 160);
    tick();
    in_x = 16'd641;
    chk("wrap_req", {31'd0, mem_req}, 1);
    chk("wrap_addr", 32'(mem_addr), 0);
    drain(400);
    chk("wrap_req_fall", {31'd0, mem_req}, 0);
    in_y = 16'd479; in_x = 16'd640;
    tick();
    in_x = 16'd641;
    chk("no_fetch_479_a", {31'd0, mem_req}, 0);
    tick();
    chk("no_fetch_479_b", {31'd0, mem_req}, 0);

    // Abort: second trigger mid-fetch restarts at k=0 and flags underrun
    mem_ack = 1'b0; in_y = 16'd9; in_x = 16'd640;
    tick();
    in_x = 16'd641;
    chk("held_req", {31'd0, mem_req}, 1);
    chk("held_addr", 32'(mem_addr), 1600);
    chk("held_underrun", {31'd0, underrun}, 0);
    push_addrs(1600, 5);
    mem_ack = 1'b1;
    repeat (5) tick();
    mem_ack = 1'b0;
    chk("abort_pre_addr", 32'(mem_addr), 1605);
    in_y = 16'd20; in_x = 16'd640;
    tick();
    in_x = 16'd641;
    chk("abort_restart_addr", 32'(mem_addr), 3360);
    chk("abort_req", {31'd0, mem_req}, 1);
    chk("abort_underrun", {31'd0, underrun}, 1);
    push_addrs(3360, 160);
    mem_ack = 1'b1;
    drain(400);
    chk("abort_done_req", {31'd0, mem_req}, 0);
    chk("abort_underrun_sticky", {31'd0, underrun}, 1);
    mem_ack = 1'b0;

    reset = 1'b1; in_x = '0; in_y = '0;
    tick(); tick();
    chk("rst2_underrun", {31'd0, underrun}, 0);
    reset = 1'b0;
    tick();

    // Late fetch: display reaches line 10 while it is still pending
    in_y = 16'd9; in_x = 16'd640;
    tick();
    in_x = 16'd641;
    tick();
    chk("late_pre_underrun", {31'd0, underrun}, 0);
    pix(16'd0, 16'd10, 1'b0, 1'b0, 12'h095);
    chk("late_underrun", {31'd0, underrun}, 1);
    in_visible = 1'b0; in_x = 16'd1;
    tick(); tick();
    chk("late_underrun_sticky", {31'd0, underrun}, 1);

    // Reset mid-fetch at k=50 with ack high
    push_addrs(1600, 50);
    mem_ack = 1'b1;
    repeat (50) tick();
    chk("k50_addr", 32'(mem_addr), 1650);
    reset = 1'b1;
    tick();
    chk("rst_mid_req", {31'd0, mem_req}, 0);
    chk("rst_mid_addr", 32'(mem_addr), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_mid_req_after", {31'd0, mem_req}, 0);
    mem_ack = 1'b0;
    pix(16'd196, 16'd10, 1'b1, 1'b0, 12'h96A);
    pix(16'd200, 16'd10, 1'b0, 1'b1, 12'hD65);
    in_visible = 1'b0;
    tick(); tick(); tick();

    chk("pix_left", exp_pix.size(), 0);
    chk("addr_left", exp_addr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
